// File: rtl/irq_capture_unit.sv
// Captures rising edges on eight request lines into a pending vector and offers
// the highest-index enabled pending line as valid/id. Event-to-offer latency 2 cycles.
// The offer holds until ack; at most one event retired per 2 cycles.
module irq_capture_unit #(
    parameter int N_REQ = 8,
    parameter int ID_W  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req_i,
    input  logic [N_REQ-1:0] mask_i,
    input  logic             ack_i,
    input  logic             clr_ovf_i,
    output logic             valid_o,
    output logic [ID_W-1:0]  id_o,
    output logic [N_REQ-1:0] pending_o,
    output logic [N_REQ-1:0] overflow_o
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_OFFER = 1'b1
    } state_t;

    state_t             state_q;
    logic               valid_q;
    logic [ID_W-1:0]    id_q;
    logic [N_REQ-1:0]   req_d_q;
    logic [N_REQ-1:0]   pending_q;
    logic [N_REQ-1:0]   pending_d;
    logic [N_REQ-1:0]   overflow_q;
    logic [N_REQ-1:0]   overflow_d;
    logic [N_REQ-1:0]   rise_w;
    logic [N_REQ-1:0]   retire_w;
    logic [N_REQ-1:0]   enabled_w;
    logic               accept_w;

    // Highest-index-wins encode: later (higher) set bits overwrite earlier ones.
    function automatic logic [ID_W-1:0] hi_index(input logic [N_REQ-1:0] v);
        logic [ID_W-1:0] r;
        r = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (v[i]) begin
                r = ID_W'(i);
            end
        end
        return r;
    endfunction

    // Edge detect, retire decode and next-state for pending/overflow vectors.
    always_comb begin
        rise_w    = req_i & ~req_d_q;
        accept_w  = (state_q == S_OFFER) && ack_i;
        retire_w  = '0;
        if (accept_w) begin
            retire_w[id_q] = 1'b1;
        end
        // A rise on the line being retired re-arms it, so set beats clear.
        pending_d  = (pending_q & ~retire_w) | rise_w;
        // A second event on a line still waiting is lost; flag it. Set beats clear.
        overflow_d = (clr_ovf_i ? '0 : overflow_q) | (rise_w & pending_q & ~retire_w);
        enabled_w  = pending_q & mask_i;
    end

    // Request history, pending and overflow registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_d_q    <= '0;
            pending_q  <= '0;
            overflow_q <= '0;
        end else begin
            req_d_q    <= req_i;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    // Offer FSM: select once from the registered pending vector, then hold until ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            id_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (|enabled_w) begin
                        state_q <= S_OFFER;
                        valid_q <= 1'b1;
                        id_q    <= hi_index(enabled_w);
                    end
                end
                S_OFFER: begin
                    // No pre-emption and no withdrawal on mask change; only ack ends it.
                    if (ack_i) begin
                        state_q <= S_IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign valid_o    = valid_q;
    assign id_o       = id_q;
    assign pending_o  = pending_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_irq_capture_unit.sv
module tb_irq_capture_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] req = 8'h00;
    logic [7:0] mask = 8'hFF;
    logic       ack = 1'b0;
    logic       clr_ovf = 1'b0;
    logic       valid;
    logic [2:0] id;
    logic [7:0] pending;
    logic [7:0] overflow;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [7:0] m_prev;
    logic [7:0] m_pend;
    logic [7:0] m_ovf;
    bit         m_offer;
    int         m_id;

    irq_capture_unit dut (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req),
        .mask_i     (mask),
        .ack_i      (ack),
        .clr_ovf_i  (clr_ovf),
        .valid_o    (valid),
        .id_o       (id),
        .pending_o  (pending),
        .overflow_o (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int top_bit(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_prev  = 8'h00;
        m_pend  = 8'h00;
        m_ovf   = 8'h00;
        m_offer = 0;
        m_id    = 0;
    endtask

    // One clock edge of the spec's rules, evaluated from the pre-edge state.
    task automatic model_edge();
        logic [7:0] rise;
        logic [7:0] ret;
        logic [7:0] np;
        logic [7:0] no;
        rise = req & ~m_prev;
        ret  = (m_offer && ack) ? (8'h01 << m_id) : 8'h00;
        np   = 8'h00;
        no   = clr_ovf ? 8'h00 : m_ovf;
        for (int i = 0; i < 8; i++) begin
            if (rise[i]) np[i] = 1'b1;
            else if (ret[i]) np[i] = 1'b0;
            else np[i] = m_pend[i];
            if (rise[i] && m_pend[i] && !ret[i]) no[i] = 1'b1;
        end
        if (m_offer) begin
            if (ack) m_offer = 0;
        end else if ((m_pend & mask) != 8'h00) begin
            m_offer = 1;
            m_id    = top_bit(m_pend & mask);
        end
        m_pend = np;
        m_ovf  = no;
        m_prev = req;
    endtask

    task automatic compare_model();
        chk("model_valid", {7'd0, valid}, {7'd0, m_offer});
        chk("model_pending", pending, m_pend);
        chk("model_overflow", overflow, m_ovf);
        if (m_offer) chk("model_id", {5'd0, id}, 8'(m_id));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_model();
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        // Reset and idle
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("reset_valid", {7'd0, valid}, 8'h00);
        chk("reset_id", {5'd0, id}, 8'h00);
        chk("reset_pending", pending, 8'h00);
        chk("reset_overflow", overflow, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        steps(10);
        chk("idle_pending", pending, 8'h00);

        // Two simultaneous events, acked as offered
        req = 8'h24;
        step();
        chk("pair_pending", pending, 8'h24);
        chk("pair_not_yet_valid", {7'd0, valid}, 8'h00);
        req = 8'h00;
        step();
        chk("pair_first_valid", {7'd0, valid}, 8'h01);
        chk("pair_first_id", {5'd0, id}, 8'h05);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("pair_gap_valid", {7'd0, valid}, 8'h00);
        step();
        chk("pair_second_id", {5'd0, id}, 8'h02);

        // Higher-priority arrival does not pre-empt
        req = 8'h80;
        step();
        req = 8'h00;
        step();
        chk("nopreempt_id", {5'd0, id}, 8'h02);
        ack = 1'b1;
        step();
        ack = 1'b0;
        step();
        chk("after_preempt_id", {5'd0, id}, 8'h07);
        ack = 1'b1;
        step();
        ack = 1'b0;
        step();
        chk("pair_end_pending", pending, 8'h00);

        // Masked event captured but not offered until enabled
        mask = 8'h0F;
        req = 8'h40;
        step();
        req = 8'h00;
        steps(3);
        chk("masked_pending", pending, 8'h40);
        chk("masked_valid", {7'd0, valid}, 8'h00);
        mask = 8'hFF;
        steps(2);
        chk("unmasked_id", {5'd0, id}, 8'h06);
        ack = 1'b1;
        step();
        ack = 1'b0;
        step();

        // Overflow, clear, and rise coinciding with retire
        req = 8'h08;
        step();
        req = 8'h00;
        steps(2);
        req = 8'h08;
        step();
        req = 8'h00;
        step();
        chk("ovf_set", overflow, 8'h08);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        chk("ovf_cleared", overflow, 8'h00);
        chk("ovf_offer_id", {5'd0, id}, 8'h03);
        req = 8'h08;
        ack = 1'b1;
        step();
        req = 8'h00;
        ack = 1'b0;
        chk("rise_on_ack_pending", pending & 8'h08, 8'h08);
        chk("rise_on_ack_ovf", overflow, 8'h00);
        step();
        ack = 1'b1;
        step();
        ack = 1'b0;
        step();

        // Randomised traffic against the model
        for (int c = 0; c < 400; c++) begin
            req = 8'($urandom) & 8'($urandom);
            ack = ($urandom_range(0, 2) != 0);
            clr_ovf = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 7) == 0) mask = 8'($urandom);
            step();
        end
        req = 8'h00;
        ack = 1'b0;
        clr_ovf = 1'b0;
        mask = 8'hFF;
        step();

        // Line held high across reset release is one event
        req = 8'h02;
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("held_pending", pending, 8'h02);
        step();
        chk("held_id", {5'd0, id}, 8'h01);
        ack = 1'b1;
        step();
        ack = 1'b0;
        steps(4);
        chk("held_once_pending", pending, 8'h00);
        chk("held_once_valid", {7'd0, valid}, 8'h00);

        // Reset mid-offer with overflow set
        req = 8'h00;
        step();
        req = 8'h04;
        step();
        req = 8'h00;
        steps(2);
        req = 8'h04;
        step();
        req = 8'h00;
        chk("pre_rst_valid", {7'd0, valid}, 8'h01);
        chk("pre_rst_ovf", overflow, 8'h04);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_valid", {7'd0, valid}, 8'h00);
        chk("midrst_pending", pending, 8'h00);
        chk("midrst_overflow", overflow, 8'h00);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        steps(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/irq_capture_unit.md
# irq_capture_unit

Front end for the 8-to-3 priority encoding path. It turns eight asynchronous-event request lines into latched, maskable pending events. It presents the highest-index enabled pending event as a `valid`/`id` offer to the downstream consumer and retires it on `ack`. Its pending vector is what a highest-index-wins 8-to-3 priority encode operates on, so `id` is always the 3-bit code of the highest set bit of `pending & mask` at the moment of selection.

## Interface
- `N_REQ`, 8: number of request lines; fixed at 8 for this revision.
- `ID_W`, 3: width of `id`.

- `clk`  in  1  single clock; all state updates on its rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req`  in  8  request lines; a 0->1 transition is one event
- `mask`  in  8  1 = line enabled for presentation; masked events are still captured
- `ack`  in  1  consumer accepts the current offer; only meaningful while `valid`=1
- `clr_ovf`  in  1  clears all `overflow` bits
- `valid`  out  1  offer present
- `id`  out  3  index of the offered line; valid only while `valid`=1
- `pending`  out  8  latched, not-yet-retired events
- `overflow`  out  8  sticky; an event arrived on a line already pending

## Operation
- Edge detect: register `req_d` ← `req` every cycle; `rise = req & ~req_d`.
  - `req_d` resets to 0, so a line held high through reset release counts as one event.
- Pending, per bit i, with priority top-down:
  - `rise[i]` → set.
  - Retire of i (ack accepted with `id`=i) → clear.
  - Otherwise hold.
  - Rise and retire on the same bit in the same cycle: set wins; the bit stays pending.
- Overflow, per bit i:
  - Set when `rise[i]` occurs, `pending[i]`=1 and bit i is not retired in that cycle.
  - Cleared by `clr_ovf`. Set wins over a simultaneous `clr_ovf`.
- FSM states: IDLE, OFFER.
  - IDLE: `valid`=0. If `pending & mask` ≠ 0, latch `id` = highest set index of `pending & mask` (current registered value) and go to OFFER.
  - OFFER: `valid`=1; `id` held stable.
    - A higher-priority arrival does not pre-empt the offer.
    - Clearing the mask bit of `id` does not withdraw the offer.
    - On `ack`=1: retire `pending[id]` and return to IDLE.
- `ack` while in IDLE is ignored: no state change, nothing cleared.
- `id` holds its last value in IDLE. The consumer must not sample it while `valid`=0.
- Reset values (asynchronous): state=IDLE, `valid`=0, `id`=0, `pending`=0, `overflow`=0, `req_d`=0.

## Timing
- `req[i]` first seen high at edge t → `pending[i]`=1 after t.
  - If IDLE and enabled: `valid`=1, `id`=i after t+1.
  - Event-to-offer latency is 2 cycles.
- `ack` sampled at edge a → after a: `valid`=0, pending bit cleared.
  - Earliest next `valid`=1 is after a+1, so there is a mandatory one-cycle gap between offers.
- Maximum throughput: one event retired per 2 cycles.
- A `req` pulse of at least one clock high is captured. Pulses shorter than a clock period may be missed; synchronising `req` is the upstream's responsibility.
- `rst` asserted mid-offer: everything clears immediately, including pending and overflow. No event survives reset.

## Test plan
- Reset, then `req`=8'h00 and `mask`=8'hFF for 10 cycles → `valid`=0, `pending`=0, `overflow`=0 throughout.
- `mask`=8'hFF; pulse `req[5]` and `req[2]` together for 1 cycle; `ack` each offer the cycle it appears → `pending`=8'h24 after 1 cycle; first offer `id`=5 at cycle 2; after its ack, `id`=2 offered 2 cycles later; `pending`=0 at end.
- While `id`=2 is offered (no ack), pulse `req[7]` → `id` stays 2. After ack, the next offer has `id`=7.
- `mask`=8'h0F; pulse `req[6]` → `pending[6]`=1, `valid` stays 0. Set `mask`=8'hFF → `valid`=1, `id`=6 two cycles later.
- Pulse `req[3]` twice (separated by 2 low cycles) with no ack → `overflow`=8'h08. `clr_ovf` pulse → `overflow`=0. A third rise on the exact cycle of ack of `id`=3 → `pending[3]` stays 1, `overflow` stays 0.
- Hold `req[1]`=1 across reset release → exactly one event on line 1. Assert `rst` mid-offer → `valid`, `pending` and `overflow` are 0 immediately, before the next edge.
